// File: rtl/bus_mux_arb_if.sv
// Handshake and data bundle between the producers, the mux/arbiter and the downstream consumer.
// Both sides use valid/ready: a word moves on a rising edge where valid and ready are both high.
interface bus_mux_arb_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SELW     = $clog2(CHANNELS)
);
    logic                      mode;
    logic [SELW-1:0]           sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_ch;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/bus_mux_arb.sv
// N-channel registered bus multiplexer: explicit select or round-robin arbitration
// into a single output register that sustains one word per cycle.
module bus_mux_arb #(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic            clk,
    input  logic            rst_n,
    bus_mux_arb_if.slave    bus,
    output logic            dbg_full,
    output logic [SELW-1:0] dbg_ptr
);
    localparam int NSEL = 1 << SELW;
    localparam logic [SELW-1:0] PTR_RST = SELW'(CHANNELS - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state;
    logic [WIDTH-1:0]  data_q;
    logic [SELW-1:0]   ch_q;
    logic [SELW-1:0]   ptr;

    logic [WIDTH-1:0]  words [CHANNELS];
    logic [NSEL-1:0]   valid_ext;
    logic              load_en;
    logic              rr_valid;
    logic [SELW-1:0]   rr_idx;
    logic [SELW-1:0]   cand;
    logic              grant_valid;
    logic [SELW-1:0]   grant_idx;
    logic              xfer;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign words[k] = bus.in_data[k*WIDTH +: WIDTH];
    end

    // Padding to a power of two makes out-of-range sel values read as "not valid".
    assign valid_ext = NSEL'(bus.in_valid);
    assign load_en   = (state == EMPTY) | bus.out_ready;

    always_comb begin
        rr_valid = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = SELW'((int'(ptr) + i) % CHANNELS);
            if (!rr_valid && valid_ext[cand]) begin
                rr_valid = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (bus.mode) begin
            grant_valid = rr_valid;
            grant_idx   = rr_idx;
        end else begin
            grant_valid = valid_ext[bus.sel];
            grant_idx   = bus.sel;
        end
    end

    assign xfer = rst_n & grant_valid & load_en;

    always_comb begin
        bus.in_ready = '0;
        if (xfer) begin
            bus.in_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EMPTY;
            data_q <= '0;
            ch_q   <= '0;
            ptr    <= PTR_RST;
        end else begin
            case (state)
                EMPTY: begin
                    if (xfer) begin
                        state  <= FULL;
                        data_q <= words[grant_idx];
                        ch_q   <= grant_idx;
                        if (bus.mode) ptr <= grant_idx;
                    end
                end
                FULL: begin
                    // Drain and reload in the same edge keeps the bus bubble-free.
                    if (xfer) begin
                        data_q <= words[grant_idx];
                        ch_q   <= grant_idx;
                        if (bus.mode) ptr <= grant_idx;
                    end else if (bus.out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign dbg_full      = (state == FULL);
    assign dbg_ptr       = ptr;
endmodule

// File: doc/bus_mux_arb.md
# bus_mux_arb

Parametrised N-channel, W-bit registered bus multiplexer with valid/ready handshaking. It supersedes the fixed 16-bit 2:1 bus mux wherever several producers share one datapath bus. Two selection modes are supported: explicit select and round-robin arbitration. A single output register stage provides full-throughput transfer at one word per cycle.

## Interface
Parameters:
- WIDTH, 16, data width of each channel and of the output bus.
- CHANNELS, 4, number of input channels; legal range 2..8.
- SELW, $clog2(CHANNELS), width of select/channel-index fields (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- mode  input  1  0 = explicit select via sel; 1 = round-robin arbitration.
- sel  input  SELW  channel index used when mode = 0.
- in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; at most one bit high per cycle.
- out_data  output  WIDTH  registered selected word.
- out_ch  output  SELW  index of the channel that produced out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word this cycle.

## Operation
- Output register state: EMPTY (out_valid = 0) or FULL (out_valid = 1).
- load_en = !out_valid | out_ready. The register accepts a new word when it is empty or is being drained in the same cycle.
- Grant, combinational:
  - mode 0: grant channel sel if sel < CHANNELS and in_valid[sel]. Otherwise there is no grant; other valid channels are ignored.
  - mode 1: search channels starting at (ptr+1) mod CHANNELS, wrapping upward. The first channel with in_valid = 1 is granted.
- in_ready[g] = grant_valid & load_en for the granted channel g. All other bits are 0.
- Transfer on channel g occurs when in_valid[g] & in_ready[g]. On the next edge: out_data <= word g, out_ch <= g, out_valid <= 1.
- Drain with no new transfer (out_valid & out_ready & !grant_valid): out_valid <= 0. out_data and out_ch hold their old values.
- Round-robin pointer ptr (SELW bits) updates to g only on a transfer made in mode 1. Mode 0 transfers leave ptr unchanged.
- mode or sel changes affect only the next grant decision. A held output word is never altered.
- Reset (rst_n = 0 at an edge):
  - out_valid = 0, out_data = 0, out_ch = 0.
  - ptr = CHANNELS-1, so channel 0 has first priority.
  - Reset mid-transfer discards the held word. in_ready is forced to 0 while rst_n = 0.

## Timing
- Latency: 1 cycle from an input transfer to out_valid/out_data.
- Throughput: 1 word/cycle while out_ready stays high.
- When out_valid & !out_ready: out_data and out_ch are stable and all in_ready bits are 0.
- in_ready depends combinationally on out_ready, in_valid, mode, sel and ptr. There is no combinational path from in_data to any output.
- Simultaneous drain and load in one cycle: the new word replaces the old word with no bubble.
- Producers must hold in_valid and in_data stable until their transfer completes. The block never drops an accepted word.

## Test plan
- Reset, WIDTH = 16, CHANNELS = 4: hold rst_n = 0 for 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, out_ch = 0, in_ready = 0000. First grant after release, mode 1 -> channel 0.
- Explicit select: mode = 0, sel = 2, in_valid = 1111, in_data ch2 = 16'hA5A5, out_ready = 1 -> in_ready = 0100 and the next cycle shows out_data = A5A5, out_ch = 2. Then sel = 3 with in_valid[3] = 0 -> no grant, and out_valid falls next cycle.
- Round-robin fairness: mode = 1, all channels valid, out_ready = 1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with no idle cycles.
- Backpressure: out_ready = 0 for 3 cycles while FULL -> out_data and out_ch unchanged, in_ready = 0000. On release, drain and load happen in the same cycle with no bubble.
- Sparse round-robin: ptr = 1, in_valid = 1001 -> grant channel 3, then channel 0, with wrap-around verified.
- Reset mid-operation: assert rst_n = 0 while FULL with out_ready = 0 -> out_valid = 0 next edge, the word is discarded, and ptr returns so that channel 0 has priority.
